// File: rtl/cpu_defs.sv
// Shared CPU datapath parameters: widths, register indices and reset values.
package cpu_defs;

   localparam int unsigned WIDTH  = 16;
   localparam int unsigned NREGS  = 16;
   localparam int unsigned ADDR_W = 4;

   typedef logic [WIDTH-1:0]  word_t;
   typedef logic [ADDR_W-1:0] addr_t;

   localparam addr_t REG_ZERO = ADDR_W'(0);
   localparam addr_t REG_SP   = ADDR_W'(2);
   localparam word_t SP_INIT  = 16'h7FFE;

endpackage

// File: rtl/regfile_bank.sv
// Architectural register storage: one write port, two combinational read ports.
// Register 0 reads as zero and ignores writes; register SP resets to SP_INIT.
module regfile_bank
   import cpu_defs::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr_w,
   input  logic [WIDTH-1:0]  data_w,
   input  logic [ADDR_W-1:0] raddr_a,
   input  logic [ADDR_W-1:0] raddr_b,
   output logic [WIDTH-1:0]  rdata_a_c,
   output logic [WIDTH-1:0]  rdata_b_c
);

   word_t regs_q [NREGS];
   word_t regs_d [NREGS];

   // Next-state of the array: apply the writeback unless it targets reg 0.
   always_comb begin
      regs_d = regs_q;
      if (we && (addr_w != REG_ZERO)) begin
         regs_d[addr_w] = data_w;
      end
   end

   // Storage flops with per-register reset values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs_q[i] <= (i == 32'(REG_SP)) ? SP_INIT : '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Read ports, with reg 0 masked to zero regardless of storage contents.
   always_comb begin
      rdata_a_c = (raddr_a == REG_ZERO) ? '0 : regs_q[raddr_a];
      rdata_b_c = (raddr_b == REG_ZERO) ? '0 : regs_q[raddr_b];
   end

endmodule

// File: rtl/operand_regfile.sv
// Register file with latched dual-read operand stage feeding adder16b.
// Same-cycle writeback is forwarded into the operand latches.
module operand_regfile
   import cpu_defs::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr_w,
   input  logic [WIDTH-1:0]  data_w,
   output logic [WIDTH-1:0]  out_a,
   output logic [WIDTH-1:0]  out_b,
   output logic              out_valid
);

   word_t rdata_a_c;
   word_t rdata_b_c;
   word_t out_a_q, out_a_d;
   word_t out_b_q, out_b_d;
   logic  out_valid_q, out_valid_d;

   regfile_bank u_bank (
      .clk       (clk),
      .reset     (reset),
      .we        (we),
      .addr_w    (addr_w),
      .data_w    (data_w),
      .raddr_a   (addr_a),
      .raddr_b   (addr_b),
      .rdata_a_c (rdata_a_c),
      .rdata_b_c (rdata_b_c)
   );

   // Operand select: zero reg, then writeback bypass, then stored value; hold when idle.
   always_comb begin
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      out_valid_d = rd_en;
      if (rd_en) begin
         if (addr_a == REG_ZERO)               out_a_d = '0;
         else if (we && (addr_w == addr_a))    out_a_d = data_w;
         else                                  out_a_d = rdata_a_c;
         if (addr_b == REG_ZERO)               out_b_d = '0;
         else if (we && (addr_w == addr_b))    out_b_d = data_w;
         else                                  out_b_d = rdata_b_c;
      end
   end

   // Operand latches and capture strobe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_a_q     <= '0;
         out_b_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_a     = out_a_q;
   assign out_b     = out_b_q;
   assign out_valid = out_valid_q;

endmodule
